// File: rtl/add_nrsr.sv
// Horizontal 3-tap noise reduction followed by unsharp detail restore on the sensor pixel bus.
// Latency: 3 clk_72m cycles for every field. Backpressure: none, one pixel accepted per cycle.
`timescale 1ns/1ps

package fe_sens_pkg;
    localparam int FE_DW = 12;

    typedef struct packed {
        logic             vs;
        logic             hs;
        logic             de;
        logic [FE_DW-1:0] pix;
    } fe_sens_bus_t;
endpackage

module add_nrsr
    import fe_sens_pkg::*;
#(
    parameter int DW      = FE_DW,
    parameter bit NR_EN   = 1'b1,
    parameter int SR_GAIN = 2
) (
    input  logic         clk_72m,
    input  logic         xreset,
    input  fe_sens_bus_t sens_bus_in,
    output fe_sens_bus_t sens_bus_out
);

    // Gain is in quarter units; out-of-range settings saturate to 0..7.
    localparam int              GAIN   = (SR_GAIN < 0) ? 0 : ((SR_GAIN > 7) ? 7 : SR_GAIN);
    localparam int              PW     = DW + 4;
    localparam logic signed [4:0] GAIN_S = 5'(GAIN);

    fe_sens_bus_t s0;
    fe_sens_bus_t s1;
    logic         s2_de;
    logic [DW-1:0] s2_pix;

    logic [DW-1:0]        pix_l;
    logic [DW-1:0]        pix_c;
    logic [DW-1:0]        pix_r;
    logic [DW+1:0]        sum;
    logic [DW-1:0]        nr;
    logic signed [DW:0]   d;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] t;
    logic signed [PW-1:0] y;
    logic [DW-1:0]        pix_y;
    logic                 unused_rnd;

    // Neighbours outside the active line are replaced by the centre pixel.
    always_comb begin
        pix_c = s1.pix;
        pix_l = s2_de ? s2_pix : s1.pix;
        pix_r = s0.de ? s0.pix : s1.pix;
        sum   = {2'b00, pix_l} + {1'b0, pix_c, 1'b0} + {2'b00, pix_r} + (DW+2)'(2);
        nr    = NR_EN ? sum[DW+1:2] : pix_c;
    end

    assign unused_rnd = ^sum[1:0];

    // Detail term: floor((c - nr) * gain / 4), added back onto the smoothed value.
    always_comb begin
        d    = $signed({1'b0, pix_c}) - $signed({1'b0, nr});
        prod = PW'(d) * PW'(GAIN_S);
        t    = prod >>> 2;
        y    = PW'($signed({1'b0, nr})) + t;
    end

    always_comb begin
        pix_y = y[DW-1:0];
        if (y[PW-1]) begin
            pix_y = '0;
        end else if (|y[PW-2:DW]) begin
            pix_y = '1;
        end
    end

    // xreset deassertion is expected to be aligned to clk_72m by the reset generator.
    always_ff @(posedge clk_72m or negedge xreset) begin
        if (!xreset) begin
            s0           <= '0;
            s1           <= '0;
            s2_de        <= 1'b0;
            s2_pix       <= '0;
            sens_bus_out <= '0;
        end else begin
            s0               <= sens_bus_in;
            s1               <= s0;
            s2_de            <= s1.de;
            s2_pix           <= s1.pix;
            sens_bus_out.vs  <= s1.vs;
            sens_bus_out.hs  <= s1.hs;
            sens_bus_out.de  <= s1.de;
            sens_bus_out.pix <= s1.de ? pix_y : '0;
        end
    end

endmodule

// File: tb/tb_add_nrsr.sv
// Directed bench for add_nrsr: five parameter variants share one input stream.
`timescale 1ns/1ps

module tb_add_nrsr;
    import fe_sens_pkg::*;

    logic         clk_72m = 1'b0;
    logic         xreset;
    fe_sens_bus_t bus_in;
    fe_sens_bus_t out_g2, out_g4, out_g0, out_g7, out_n0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        vs;
        logic        hs;
        logic        de;
        logic [11:0] pix;
        logic [11:0] e2;
        logic [11:0] e4;
        logic [11:0] e0;
        logic [11:0] e7;
        logic [11:0] en;
    } vec_t;

    vec_t vq[$];

    always #7 clk_72m = ~clk_72m;

    add_nrsr u_g2 (.clk_72m(clk_72m), .xreset(xreset), .sens_bus_in(bus_in), .sens_bus_out(out_g2));
    add_nrsr #(.SR_GAIN(4)) u_g4 (.clk_72m(clk_72m), .xreset(xreset), .sens_bus_in(bus_in), .sens_bus_out(out_g4));
    add_nrsr #(.SR_GAIN(0)) u_g0 (.clk_72m(clk_72m), .xreset(xreset), .sens_bus_in(bus_in), .sens_bus_out(out_g0));
    add_nrsr #(.SR_GAIN(7)) u_g7 (.clk_72m(clk_72m), .xreset(xreset), .sens_bus_in(bus_in), .sens_bus_out(out_g7));
    add_nrsr #(.NR_EN(1'b0), .SR_GAIN(2)) u_n0 (.clk_72m(clk_72m), .xreset(xreset), .sens_bus_in(bus_in), .sens_bus_out(out_n0));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic add(input logic vs, input logic hs, input logic de, input int pix,
                       input int e2, input int e4, input int e0, input int e7, input int en);
        vec_t v;
        v.vs = vs; v.hs = hs; v.de = de; v.pix = 12'(pix);
        v.e2 = 12'(e2); v.e4 = 12'(e4); v.e0 = 12'(e0); v.e7 = 12'(e7); v.en = 12'(en);
        vq.push_back(v);
    endtask

    task automatic add_all(input logic vs, input logic hs, input logic de, input int pix, input int e);
        add(vs, hs, de, pix, e, e, e, e, e);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, " g2"}, {17'd0, out_g2}, 32'd0);
        check_eq({tag, " g4"}, {17'd0, out_g4}, 32'd0);
        check_eq({tag, " g0"}, {17'd0, out_g0}, 32'd0);
        check_eq({tag, " g7"}, {17'd0, out_g7}, 32'd0);
        check_eq({tag, " n0"}, {17'd0, out_n0}, 32'd0);
    endtask

    task automatic check_out(input int idx);
        vec_t v;
        v = vq[idx];
        check_eq($sformatf("sync v%0d", idx), {29'd0, out_g2.vs, out_g2.hs, out_g2.de}, {29'd0, v.vs, v.hs, v.de});
        check_eq($sformatf("sync_n0 v%0d", idx), {29'd0, out_n0.vs, out_n0.hs, out_n0.de}, {29'd0, v.vs, v.hs, v.de});
        check_eq($sformatf("g2 pix v%0d", idx), {20'd0, out_g2.pix}, {20'd0, v.e2});
        check_eq($sformatf("g4 pix v%0d", idx), {20'd0, out_g4.pix}, {20'd0, v.e4});
        check_eq($sformatf("g0 pix v%0d", idx), {20'd0, out_g0.pix}, {20'd0, v.e0});
        check_eq($sformatf("g7 pix v%0d", idx), {20'd0, out_g7.pix}, {20'd0, v.e7});
        check_eq($sformatf("n0 pix v%0d", idx), {20'd0, out_n0.pix}, {20'd0, v.en});
    endtask

    // Drive entries from..to one per cycle; each output is checked three cycles after its input.
    task automatic play(input int from, input int to);
        for (int n = from; n <= to + 3; n++) begin
            @(negedge clk_72m);
            if (n - 3 >= from) check_out(n - 3);
            else check_zero($sformatf("flush %0d", n - from));
            if (n <= to) begin
                bus_in.vs  = vq[n].vs;
                bus_in.hs  = vq[n].hs;
                bus_in.de  = vq[n].de;
                bus_in.pix = vq[n].pix;
            end else begin
                bus_in = '0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p1_last;
        int p2_first;
        int p2_last;

        // Frame start and blanking with non-zero pixel data
        add_all(1, 1, 0, 555, 0);
        add_all(1, 0, 0, 0, 0);
        add_all(0, 1, 0, 0, 0);
        // Flat line
        for (int i = 0; i < 16; i++) add_all(0, 0, 1, 100, 100);
        add_all(0, 1, 0, 0, 0);
        add_all(0, 0, 0, 0, 0);
        // Impulse line: e2, e4, e0, e7, nr-off
        add(0, 0, 1,   0,   0,   0,   0,   0,   0);
        add(0, 0, 1,   0,  50,   0, 100,   0,   0);
        add(0, 0, 1, 400, 300, 400, 200, 550, 400);
        add(0, 0, 1,   0,  50,   0, 100,   0,   0);
        add(0, 0, 1,   0,   0,   0,   0,   0,   0);
        add_all(0, 1, 0, 0, 0);
        add_all(0, 0, 0, 0, 0);
        // Clipping line
        add(0, 0, 1,    0,    0,    0,    0,    0,    0);
        add(0, 0, 1,    0,  512,    0, 1024,    0,    0);
        add(0, 0, 1, 4095, 3583, 4095, 3071, 4095, 4095);
        add(0, 0, 1, 4095, 4095, 4095, 4095, 4095, 4095);
        add_all(0, 1, 0, 0, 0);
        add_all(0, 0, 0, 0, 0);
        // Single-pixel line, then blanking with data present
        add_all(0, 0, 1, 777, 777);
        add_all(0, 0, 0, 555, 0);
        add_all(0, 1, 0, 0, 0);
        // Rounding (half-up in NR) and floor of negative detail term
        add(0, 0, 1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 2, 2, 2, 2, 2, 2);
        add_all(0, 0, 0, 0, 0);
        p1_last = vq.size() - 1;
        // Post-reset line: first pixel acts as line start
        p2_first = vq.size();
        add(0, 0, 1, 400, 350, 400, 300, 475, 400);
        add(0, 0, 1,   0,  50,   0, 100,   0,   0);
        add_all(0, 1, 0, 0, 0);
        p2_last = vq.size() - 1;

        xreset = 1'b0;
        bus_in = '0;
        #3;
        check_zero("reset t0");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_72m);
            check_zero($sformatf("in reset %0d", i));
            bus_in = 15'($urandom);
        end
        @(negedge clk_72m);
        check_zero("reset end");
        bus_in = '0;
        xreset = 1'b1;

        play(0, p1_last);

        // Reset asserted in the middle of an active line
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_72m);
            if (i == 5) begin
                check_eq("pre-reset de", {31'd0, out_g2.de}, 32'd1);
                check_eq("pre-reset pix", {20'd0, out_g2.pix}, 32'd100);
            end
            bus_in.vs  = 1'b0;
            bus_in.hs  = 1'b0;
            bus_in.de  = 1'b1;
            bus_in.pix = 12'd100;
        end
        #3;
        xreset = 1'b0;
        #1;
        check_zero("async reset");
        @(negedge clk_72m);
        check_zero("held reset");
        bus_in = '0;
        @(negedge clk_72m);
        xreset = 1'b1;

        play(p2_first, p2_last);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
